// File: rtl/artec_dma_pkg.sv
// rtl/artec_dma_pkg.sv - shared defaults and packed entry types for the WRR task/data arbiter
package artec_dma_pkg;

  localparam int ARB_CH_NUM     = 4;
  localparam int ARB_CH_NUM_L   = $clog2(ARB_CH_NUM);
  localparam int ARB_DATA_W     = 64;
  localparam int ARB_TASK_W     = 32;
  localparam int ARB_LEN_W      = 8;
  localparam int ARB_WEIGHT_W   = 4;
  localparam int ARB_TASK_DEPTH = 4;
  localparam int ARB_EXE_DEPTH  = 4;
  localparam int ARB_DATA_DEPTH = 16;

  typedef struct packed {
    logic [ARB_CH_NUM_L-1:0] idx;
    logic [ARB_LEN_W-1:0]    len;
    logic [ARB_TASK_W-1:0]   payload;
  } arb_wrr_task_t;

  typedef struct packed {
    logic [ARB_CH_NUM_L-1:0] idx;
    logic [ARB_LEN_W-1:0]    len;
  } arb_wrr_exe_t;

  typedef struct packed {
    logic [ARB_CH_NUM_L-1:0] idx;
    logic                    last;
    logic [ARB_DATA_W-1:0]   data;
  } arb_wrr_data_t;

endpackage

// File: rtl/artec_dma_sync_fifo.sv
// rtl/artec_dma_sync_fifo.sv - single-clock first-word-fall-through FIFO, power-of-2 depth
module artec_dma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty depend only on the pointers, so a same-cycle pop never frees a slot early.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/artec_dma_wrr_sched.sv
// rtl/artec_dma_wrr_sched.sv - weighted round-robin / strict-priority grant selection
module artec_dma_wrr_sched #(
  parameter int CH_NUM   = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [CH_NUM-1:0]          eligible,
  input  logic [CH_NUM*WEIGHT_W-1:0] weight,
  output logic                       grant_valid,
  output logic [$clog2(CH_NUM)-1:0]  grant
);

  localparam int CH_L = $clog2(CH_NUM);
  localparam logic [CH_L:0]   CH_CNT   = (CH_L+1)'(CH_NUM);
  localparam logic [CH_L-1:0] LAST_IDX = CH_L'(CH_NUM - 1);

  logic [CH_L-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [WEIGHT_W-1:0] wt_q, wt_d;
  logic [CH_L-1:0]     rr_grant, sp_grant;
  logic                rr_found, sp_found;
  logic [CH_L:0]       j;
  logic                cont;
  logic [WEIGHT_W-1:0] limit;
  logic [WEIGHT_W-1:0] base;

  // Round-robin search starts at the pointer itself so the current holder keeps its run.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    sp_found = 1'b0;
    sp_grant = '0;
    j        = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      j = {1'b0, ptr_q} + (CH_L+1)'(k);
      if (j >= CH_CNT) j = j - CH_CNT;
      if (!rr_found && eligible[j[CH_L-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = j[CH_L-1:0];
      end
      if (!sp_found && eligible[k]) begin
        sp_found = 1'b1;
        sp_grant = CH_L'(k);
      end
    end
  end

  assign grant_valid = mode ? sp_found : rr_found;
  assign grant       = mode ? sp_grant : rr_grant;

  // A fresh tenure samples weight on its first win; later wins reuse the latched copy.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    wt_d  = wt_q;
    cont  = (rr_grant == ptr_q) && (cnt_q != '0);
    limit = cont ? wt_q : weight[int'(rr_grant)*WEIGHT_W +: WEIGHT_W];
    base  = cont ? cnt_q : '0;
    if (!mode) begin
      if (rr_found) begin
        if (base == limit) begin
          ptr_d = (rr_grant == LAST_IDX) ? '0 : rr_grant + 1'b1;
          cnt_d = '0;
        end else begin
          ptr_d = rr_grant;
          cnt_d = base + 1'b1;
          wt_d  = limit;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      wt_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      wt_q  <= wt_d;
    end
  end

endmodule

// File: rtl/artec_dma_arb_wrr.sv
// rtl/artec_dma_arb_wrr.sv - multi-channel task arbiter with in-order per-task data merge
module artec_dma_arb_wrr import artec_dma_pkg::*; #(
  parameter int CH_NUM     = ARB_CH_NUM,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int TASK_W     = ARB_TASK_W,
  parameter int LEN_W      = ARB_LEN_W,
  parameter int WEIGHT_W   = ARB_WEIGHT_W,
  parameter int TASK_DEPTH = ARB_TASK_DEPTH,
  parameter int EXE_DEPTH  = ARB_EXE_DEPTH,
  parameter int DATA_DEPTH = ARB_DATA_DEPTH,
  localparam int CH_NUM_L  = $clog2(CH_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_i,
  input  logic                              mode_i,
  input  logic [CH_NUM-1:0]                 ch_en_i,
  input  logic [CH_NUM*WEIGHT_W-1:0]        weight_i,
  input  logic [CH_NUM-1:0]                 task_valid_i,
  output logic [CH_NUM-1:0]                 task_ready_o,
  input  logic [CH_NUM*(LEN_W+TASK_W)-1:0]  task_i,
  input  logic [CH_NUM-1:0]                 data_valid_i,
  output logic [CH_NUM-1:0]                 data_ready_o,
  input  logic [CH_NUM*DATA_W-1:0]          data_i,
  output logic                              task_valid_o,
  input  logic                              task_ready_i,
  output logic [CH_NUM_L+LEN_W+TASK_W-1:0]  task_o,
  output logic                              data_valid_o,
  input  logic                              data_ready_i,
  output logic [CH_NUM_L+1+DATA_W-1:0]      data_o
);

  localparam int TE_W = LEN_W + TASK_W;
  localparam int TQ_W = CH_NUM_L + TE_W;
  localparam int EQ_W = CH_NUM_L + LEN_W;
  localparam int DQ_W = CH_NUM_L + 1 + DATA_W;

  logic                flush;
  logic [CH_NUM-1:0]   eligible;
  logic                grant_valid;
  logic [CH_NUM_L-1:0] grant;

  logic [TQ_W-1:0]     tq_din, tq_dout;
  logic                tq_empty, tq_full;
  logic [EQ_W-1:0]     eq_dout;
  logic                eq_empty, eq_full, eq_pop;
  logic [DQ_W-1:0]     dq_din, dq_dout;
  logic                dq_empty, dq_full, dq_pop;

  logic                t_hs;
  logic [CH_NUM_L-1:0] head_idx;
  logic [LEN_W-1:0]    head_len;
  logic                beat_ok, beat_last, d_hs;
  logic [LEN_W-1:0]    beat_cnt;

  assign flush    = rst | clear_i;
  assign eligible = task_valid_i & ch_en_i & {CH_NUM{~tq_full & ~flush}};

  artec_dma_wrr_sched #(
    .CH_NUM   (CH_NUM),
    .WEIGHT_W (WEIGHT_W)
  ) u_sched (
    .clk         (clk),
    .rst         (flush),
    .mode        (mode_i),
    .eligible    (eligible),
    .weight      (weight_i),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    task_ready_o = '0;
    if (grant_valid) task_ready_o[grant] = 1'b1;
  end

  assign tq_din = {grant, task_i[int'(grant)*TE_W +: TE_W]};

  artec_dma_sync_fifo #(.WIDTH(TQ_W), .DEPTH(TASK_DEPTH)) u_task_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (grant_valid),
    .din   (tq_din),
    .pop   (t_hs),
    .dout  (tq_dout),
    .empty (tq_empty),
    .full  (tq_full)
  );

  // A task is only released once its exe slot exists, so its data can never overtake it.
  assign task_valid_o = ~tq_empty & ~eq_full & ~flush;
  assign task_o       = task_valid_o ? tq_dout : '0;
  assign t_hs         = task_valid_o & task_ready_i;

  artec_dma_sync_fifo #(.WIDTH(EQ_W), .DEPTH(EXE_DEPTH)) u_exe_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (t_hs),
    .din   (tq_dout[TQ_W-1 -: EQ_W]),
    .pop   (eq_pop),
    .dout  (eq_dout),
    .empty (eq_empty),
    .full  (eq_full)
  );

  assign head_idx  = eq_dout[EQ_W-1 -: CH_NUM_L];
  assign head_len  = eq_dout[LEN_W-1:0];
  assign beat_ok   = ~eq_empty & ~dq_full & ~flush;
  assign d_hs      = beat_ok & data_valid_i[head_idx];
  assign beat_last = (beat_cnt == head_len);
  assign eq_pop    = d_hs & beat_last;

  always_comb begin
    data_ready_o = '0;
    if (beat_ok) data_ready_o[head_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      beat_cnt <= '0;
    end else if (d_hs) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end
  end

  assign dq_din = {head_idx, beat_last, data_i[int'(head_idx)*DATA_W +: DATA_W]};

  artec_dma_sync_fifo #(.WIDTH(DQ_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (flush),
    .push  (d_hs),
    .din   (dq_din),
    .pop   (dq_pop),
    .dout  (dq_dout),
    .empty (dq_empty),
    .full  (dq_full)
  );

  assign data_valid_o = ~dq_empty & ~flush;
  assign data_o       = data_valid_o ? dq_dout : '0;
  assign dq_pop       = data_valid_o & data_ready_i;

endmodule

// File: tb/tb_artec_dma_arb_wrr.sv
// tb/tb_artec_dma_arb_wrr.sv - directed scoreboard bench for artec_dma_arb_wrr
module tb_artec_dma_arb_wrr;
  import artec_dma_pkg::*;

  localparam int CH = ARB_CH_NUM;
  localparam int CL = ARB_CH_NUM_L;
  localparam int DW = ARB_DATA_W;
  localparam int TW = ARB_TASK_W;
  localparam int LW = ARB_LEN_W;
  localparam int WW = ARB_WEIGHT_W;

  logic                   clk = 1'b0;
  logic                   rst, clear_i, mode_i;
  logic [CH-1:0]          ch_en_i;
  logic [CH*WW-1:0]       weight_i;
  logic [CH-1:0]          task_valid_i, task_ready_o;
  logic [CH*(LW+TW)-1:0]  task_i;
  logic [CH-1:0]          data_valid_i, data_ready_o;
  logic [CH*DW-1:0]       data_i;
  logic                   task_valid_o, task_ready_i;
  logic [CL+LW+TW-1:0]    task_o;
  logic                   data_valid_o, data_ready_i;
  logic [CL+1+DW-1:0]     data_o;

  arb_wrr_task_t task_q[$];
  arb_wrr_data_t data_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  artec_dma_arb_wrr dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .mode_i       (mode_i),
    .ch_en_i      (ch_en_i),
    .weight_i     (weight_i),
    .task_valid_i (task_valid_i),
    .task_ready_o (task_ready_o),
    .task_i       (task_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .task_valid_o (task_valid_o),
    .task_ready_i (task_ready_i),
    .task_o       (task_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] pl(input int ch);
    return 32'hA5A5_0000 | 32'(ch);
  endfunction

  function automatic logic [DW-1:0] dv(input int ch);
    return {32'hD0D0_0000 | 32'(ch), 32'h1234_5678};
  endfunction

  task automatic set_len(input int ch, input int len);
    task_i[ch*(LW+TW) +: (LW+TW)] = {LW'(len), pl(ch)};
  endtask

  task automatic expect_task(input int ch, input int len, input bit with_data);
    arb_wrr_task_t t;
    arb_wrr_data_t d;
    t.idx = CL'(ch); t.len = LW'(len); t.payload = pl(ch);
    task_q.push_back(t);
    if (with_data) begin
      for (int b = 0; b <= len; b++) begin
        d.idx = CL'(ch); d.last = (b == len); d.data = dv(ch);
        data_q.push_back(d);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    arb_wrr_task_t et;
    arb_wrr_data_t ed;
    if (task_valid_o && task_ready_i) begin
      if (task_q.size() == 0) chk("task_extra", task_q.size(), 1);
      else begin
        et = task_q.pop_front();
        chk("task_o", task_o, et);
      end
    end
    if (data_valid_o && data_ready_i) begin
      if (data_q.size() == 0) chk("data_extra", data_q.size(), 1);
      else begin
        ed = data_q.pop_front();
        chk("data_o", data_o, ed);
      end
    end
  end

  task automatic accept_n(input int n, input logic [CH-1:0] after_valid, input logic [CH-1:0] exp_mask);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 200) begin
      @(negedge clk);
      if (|task_ready_o) begin
        acc++;
        if (exp_mask != '0) chk("grant_mask", task_ready_o, exp_mask);
      end
      cyc++;
      tick();
    end
    task_valid_i = after_valid;
    chk("accept_count", acc, n);
  endtask

  task automatic wait_drain(input logic [CH-1:0] allowed);
    int cyc = 0;
    while ((task_q.size() != 0 || data_q.size() != 0) && cyc < 300) begin
      @(negedge clk);
      if (allowed != '1) chk("data_ready_mask", data_ready_o & ~allowed, 0);
      cyc++;
      tick();
    end
    chk("drain_task_q", task_q.size(), 0);
    chk("drain_data_q", data_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[12];
    int acc;
    int beats;
    int cyc;
    ord = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0};

    rst = 1'b1; clear_i = 1'b0; mode_i = 1'b0;
    ch_en_i = '1; weight_i = '0;
    task_valid_i = '1; data_valid_i = '1;
    task_ready_i = 1'b1; data_ready_i = 1'b1;
    for (int c = 0; c < CH; c++) begin
      set_len(c, 0);
      data_i[c*DW +: DW] = dv(c);
    end

    // Reset state, including ready gating while channels request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_task_ready", task_ready_o, 0);
    chk("rst_data_ready", data_ready_o, 0);
    chk("rst_task_valid", task_valid_o, 0);
    chk("rst_data_valid", data_valid_o, 0);
    chk("rst_task_o", task_o, 0);
    chk("rst_data_o", data_o, 0);
    tick();
    rst = 1'b0; task_valid_i = '0;
    @(negedge clk);
    chk("post_rst_task_valid", task_valid_o, 0);
    chk("post_rst_data_valid", data_valid_o, 0);
    tick();

    // Weighted round robin, channel 0 weight 1, others 0.
    weight_i = 16'h0001;
    for (int i = 0; i < 12; i++) expect_task(ord[i], 0, 1'b1);
    task_valid_i = '1;
    accept_n(12, '0, '0);
    wait_drain('1);

    // Strict priority: channel 1 beats channel 3 until it drops.
    mode_i = 1'b1;
    for (int i = 0; i < 5; i++) expect_task(1, 0, 1'b1);
    for (int i = 0; i < 2; i++) expect_task(3, 0, 1'b1);
    task_valid_i = 4'b1010;
    accept_n(5, 4'b1000, 4'b0010);
    accept_n(2, 4'b0000, 4'b1000);
    mode_i = 1'b0;
    wait_drain('1);

    // Multi-beat task, then a single-beat task to show the beat counter restarted.
    expect_task(2, 3, 1'b1);
    expect_task(2, 0, 1'b1);
    set_len(2, 3);
    task_valid_i = 4'b0100;
    accept_n(1, 4'b0100, 4'b0100);
    set_len(2, 0);
    accept_n(1, 4'b0000, 4'b0100);
    wait_drain(4'b0100);

    // Output stall: task FIFO fills, no data moves.
    set_len(1, 0);
    task_ready_i = 1'b0;
    task_valid_i = 4'b0010;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (task_ready_o[1]) acc++;
      chk("stall_data_ready", data_ready_o, 0);
      tick();
    end
    @(negedge clk);
    chk("stall_accepts", acc, ARB_TASK_DEPTH);
    chk("stall_task_ready", task_ready_o, 0);
    chk("stall_task_valid", task_valid_o, 1);
    tick();
    task_valid_i = '0;
    for (int i = 0; i < ARB_TASK_DEPTH; i++) expect_task(1, 0, 1'b1);
    task_ready_i = 1'b1;
    wait_drain(4'b0010);

    // Clear in the middle of an 8-beat burst.
    set_len(0, 7);
    data_ready_i = 1'b0;
    expect_task(0, 7, 1'b0);
    task_valid_i = 4'b0001;
    accept_n(1, 4'b0000, 4'b0001);
    beats = 0;
    cyc = 0;
    while (beats < 2 && cyc < 50) begin
      @(negedge clk);
      if (data_ready_o[0] && data_valid_i[0]) beats++;
      cyc++;
      tick();
    end
    chk("burst_beats", beats, 2);
    clear_i = 1'b1;
    set_len(0, 0);
    task_valid_i = 4'b0001;
    @(negedge clk);
    chk("clear_task_ready", task_ready_o, 0);
    chk("clear_data_ready", data_ready_o, 0);
    chk("clear_task_valid", task_valid_o, 0);
    chk("clear_data_valid", data_valid_o, 0);
    tick();
    clear_i = 1'b0;
    expect_task(0, 0, 1'b1);
    @(negedge clk);
    chk("post_clear_task_valid", task_valid_o, 0);
    chk("post_clear_data_valid", data_valid_o, 0);
    chk("post_clear_task_ready", task_ready_o, 4'b0001);
    tick();
    task_valid_i = '0;
    @(negedge clk);
    chk("accept_latency", task_valid_o, 1);
    tick();
    data_ready_i = 1'b1;
    wait_drain(4'b0001);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
